branch_ctrl: RTL
================

Name: branch_ctrl

Overview:
- Control-flow stage directly upstream of the program counter; produces `absjump_en` and `target` every cycle.
- Resolves conditional branches through a software-loadable branch-target LUT.
- Resolves calls and returns through a hardware return-address stack (RAS).
- Keeps sticky RAS error flags and a taken-jump counter for the testbench and debug.

Parameters:
- D, 12: PC / target width; must match the program counter.
- L, 5: LUT index width; the LUT has 2^L entries of D bits.
- S, 4: RAS depth in entries; minimum 2.
- CW, 16: width of the taken-jump counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- prog_ctr  in  D  current PC value.
- branch_req  in  1  conditional branch instruction is in decode.
- cond_flag  in  1  branch condition (e.g. zero flag); the branch is taken when 1.
- call_req  in  1  call instruction; always taken.
- ret_req  in  1  return instruction.
- lut_idx  in  L  LUT index for branch and call targets.
- lut_we  in  1  LUT write enable.
- lut_waddr  in  L  LUT write address.
- lut_wdata  in  D  LUT write data.
- absjump_en  out  1  to PC: load `target` on the next edge.
- target  out  D  absolute jump target.
- ras_ovf  out  1  sticky: a push was attempted while the RAS was full.
- ras_unf  out  1  sticky: a pop was attempted while the RAS was empty.
- jump_cnt  out  CW  number of taken jumps since reset.

Behaviour:
- Reset: one clock, synchronous, active-high. Port names are `clk` and `reset`.
- Reset action: RAS pointer=0; all LUT entries=0; `ras_ovf`=0; `ras_unf`=0; `jump_cnt`=0.
- Outputs during reset: `absjump_en`=0 and `target`=0 while reset is high, regardless of other inputs.
- Decision path is combinational, from current inputs and stored state to `absjump_en`/`target`, with zero-cycle latency. A request in cycle N makes the PC hold the new target after edge N.
- Priority when requests coincide: ret_req > call_req > branch_req. Lower-priority requests are ignored entirely: no push, no count.
- ret_req:
  - RAS non-empty: `absjump_en`=1, `target`=top of stack; pop on the edge.
  - RAS empty: `absjump_en`=0 (PC increments); `ras_unf` sets on the edge; pointer unchanged.
- call_req:
  - `absjump_en`=1, `target`=LUT[`lut_idx`].
  - Push `prog_ctr`+1 (modulo 2^D, so 'hFFF wraps to 0) on the edge.
  - RAS full: the push is dropped, `ras_ovf` sets, and the jump is still taken.
- branch_req:
  - `absjump_en`=`cond_flag`; `target`=LUT[`lut_idx`].
  - When not taken, `target` is don't-care but must still equal LUT[`lut_idx`].
- No request: `absjump_en`=0, `target`=0.
- LUT read is asynchronous.
- LUT write occurs on the edge when `lut_we`=1.
  - A same-cycle read of the written index returns the OLD value.
  - Writes are allowed concurrently with any request.
- RAS:
  - Pointer runs 0..S; full when the pointer equals S.
  - Push and pop never happen in the same cycle (guaranteed by the priority order).
- Sticky flags are cleared only by reset.
- `jump_cnt` increments on the edge after each cycle with `absjump_en`=1. It saturates at 2^CW-1 and does not wrap.
- Reset asserted mid-sequence: the RAS contents are discarded and the next cycle behaves as empty.

Decomposition:
- Shared package `cpu_pkg`:
  - constants `PC_W`=12, `LUT_IDX_W`=5, `RAS_DEPTH`=4;
  - enum `jump_kind_t` {JK_NONE, JK_BRANCH, JK_CALL, JK_RET}, produced by the priority encoder and used by the bench scoreboard.
- Sub-module `ret_stack`: parameterised D/S LIFO with push, pop, top, empty, full.
- The LUT register file, priority logic, flags and counter stay in `branch_ctrl`.

Test Plan:
1. Reset then idle: `reset`=1 for 2 cycles, then all requests 0 → `absjump_en`=0, `target`=0, `jump_cnt`=0, both flags 0.
2. LUT branch:
   - Write LUT[3]='h2A0; next cycle branch_req=1, `lut_idx`=3, cond_flag=1 → `absjump_en`=1, `target`='h2A0, then `jump_cnt`=1.
   - Repeat with cond_flag=0 → `absjump_en`=0 and `jump_cnt` unchanged.
3. Call/return pair: LUT[1]='h100, `prog_ctr`='h050, call_req=1 → `target`='h100. Later, ret_req=1 → `target`='h051, and the RAS is empty afterwards.
4. Overflow and underflow:
   - With S=4, issue 5 calls → the 5th still jumps and `ras_ovf`=1.
   - 4 returns yield the pushed addresses in LIFO order.
   - A 5th return → `absjump_en`=0 and `ras_unf`=1.
5. Simultaneous events and wrap:
   - ret_req+call_req+branch_req together with RAS top='h051 → `target`='h051 and no push.
   - call at `prog_ctr`='hFFF pushes 'h000.
   - LUT write to idx 3 in the same cycle as a branch reading idx 3 → old value used.
6. Reset mid-sequence: after 2 calls assert `reset` for 1 cycle, then ret_req=1 → `absjump_en`=0 and `ras_unf`=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the control-flow slice.
//   PC_W      : program counter / jump target width
//   LUT_IDX_W : branch-target LUT index width
//   RAS_DEPTH : return-address stack depth (entries)
//   jump_kind_t : request class after priority resolution (ret > call > branch)
package cpu_pkg;

  localparam int PC_W      = 12;
  localparam int LUT_IDX_W = 5;
  localparam int RAS_DEPTH = 4;

  typedef enum logic [1:0] {
    JK_NONE,
    JK_BRANCH,
    JK_CALL,
    JK_RET
  } jump_kind_t;

endpackage

// File: rtl/branch_ctrl_ret_stack.sv
// ret_stack: hardware return-address LIFO.
//   clk, reset : clock, synchronous active-high reset (pointer only)
//   push, din  : push din when not full (ignored when full)
//   pop        : drop the top entry when not empty (ignored when empty)
//   top        : current top-of-stack, '0 when empty
//   empty/full : pointer == 0 / pointer == S
module ret_stack #(
  parameter int D = 12,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] din,
  output logic [D-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(S + 1);

  logic [PW-1:0] ptr;
  logic [D-1:0]  mem [S];

  assign empty = (ptr == '0);
  assign full  = (ptr == PW'(S));

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
    end
  end

  // Entry storage needs no reset: a zero pointer hides stale contents.
  // Decoded per-entry compare keeps pointer and entry index widths independent.
  always_ff @(posedge clk) begin
    if (!reset && push && !full) begin
      for (int unsigned i = 0; i < S; i++) begin
        if (ptr == PW'(i)) mem[i] <= din;
      end
    end
  end

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < S; i++) begin
      if (ptr == PW'(i + 1)) top = mem[i];
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: control-flow stage feeding the program counter.
//   clk, reset           : clock, synchronous active-high reset
//   prog_ctr             : current PC
//   branch_req/cond_flag : conditional branch, taken when cond_flag=1
//   call_req / ret_req   : call (always taken, pushes PC+1) / return (pops)
//   lut_idx              : branch/call target LUT read index (async read)
//   lut_we/waddr/wdata   : LUT write port (on the edge)
//   absjump_en, target   : PC load request and absolute target (combinational)
//   ras_ovf / ras_unf    : sticky push-when-full / pop-when-empty flags
//   jump_cnt             : saturating count of taken jumps
module branch_ctrl
  import cpu_pkg::*;
#(
  parameter int D  = PC_W,
  parameter int L  = LUT_IDX_W,
  parameter int S  = RAS_DEPTH,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [D-1:0]  prog_ctr,
  input  logic          branch_req,
  input  logic          cond_flag,
  input  logic          call_req,
  input  logic          ret_req,
  input  logic [L-1:0]  lut_idx,
  input  logic          lut_we,
  input  logic [L-1:0]  lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  output logic          absjump_en,
  output logic [D-1:0]  target,
  output logic          ras_ovf,
  output logic          ras_unf,
  output logic [CW-1:0] jump_cnt
);

  logic [D-1:0] lut [2**L];
  logic [D-1:0] lut_rd;
  logic [D-1:0] ras_top;
  logic         ras_empty;
  logic         ras_full;
  logic         push;
  logic         pop;
  logic         ovf_set;
  logic         unf_set;
  jump_kind_t   kind;

  // Asynchronous read; a write on this edge is seen from the next cycle.
  assign lut_rd = lut[lut_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      lut <= '{default: '0};
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  // Priority encoder; reset masks every request so outputs stay at zero.
  always_comb begin
    kind = JK_NONE;
    if (!reset) begin
      if (ret_req)         kind = JK_RET;
      else if (call_req)   kind = JK_CALL;
      else if (branch_req) kind = JK_BRANCH;
    end
  end

  always_comb begin
    absjump_en = 1'b0;
    target     = '0;
    push       = 1'b0;
    pop        = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    case (kind)
      JK_RET: begin
        if (ras_empty) begin
          unf_set = 1'b1;
        end else begin
          absjump_en = 1'b1;
          target     = ras_top;
          pop        = 1'b1;
        end
      end
      JK_CALL: begin
        absjump_en = 1'b1;
        target     = lut_rd;
        if (ras_full) ovf_set = 1'b1;
        else          push    = 1'b1;
      end
      JK_BRANCH: begin
        absjump_en = cond_flag;
        target     = lut_rd;
      end
      default: ;
    endcase
  end

  ret_stack #(
    .D (D),
    .S (S)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (prog_ctr + D'(1)),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ovf  <= 1'b0;
      ras_unf  <= 1'b0;
      jump_cnt <= '0;
    end else begin
      if (ovf_set) ras_ovf <= 1'b1;
      if (unf_set) ras_unf <= 1'b1;
      if (absjump_en && (jump_cnt != '1)) jump_cnt <= jump_cnt + CW'(1);
    end
  end

endmodule
